// File: rtl/mtp_pkg.sv
// Shared FSM encoding and width constants for the multi-point blob tracker.
package mtp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPACT = 2'd2,
        PUBLISH = 2'd3
    } mtp_state_e;

    localparam int MTP_DEF_CW    = 16;  // default coordinate / pixel-count width
    localparam int MTP_NUM_W     = 5;   // holds 0..16 points
    localparam int MTP_MAX_SLOTS = 16;

endpackage

// File: rtl/mtp_slot.sv
// One blob slot: bounding-box registers, merge-distance match and absorb/allocate update.
module mtp_slot #(
    parameter int CW         = 16,
    parameter int MERGE_DIST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          alloc,
    input  logic          absorb,
    input  logic [CW-1:0] pix_h,
    input  logic [CW-1:0] pix_v,
    output logic          valid,
    output logic          match,
    output logic [CW-1:0] centre_h,
    output logic [CW-1:0] centre_v,
    output logic [CW-1:0] count
);

    localparam logic [CW:0]   MD      = (CW+1)'(MERGE_DIST);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          valid_reg;
    logic [CW-1:0] min_h_reg, max_h_reg, min_v_reg, max_v_reg, count_reg;
    logic [CW:0]   h_ext, v_ext, sum_h, sum_v;

    assign h_ext = {1'b0, pix_h};
    assign v_ext = {1'b0, pix_v};

    // Extra bit keeps the distance window from wrapping near the coordinate limits.
    assign match = valid_reg
                && (h_ext + MD >= {1'b0, min_h_reg})
                && (h_ext <= {1'b0, max_h_reg} + MD)
                && (v_ext <= {1'b0, max_v_reg} + MD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            min_h_reg <= '0;
            max_h_reg <= '0;
            min_v_reg <= '0;
            max_v_reg <= '0;
            count_reg <= '0;
        end else if (clr) begin
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else if (alloc) begin
            valid_reg <= 1'b1;
            min_h_reg <= pix_h;
            max_h_reg <= pix_h;
            min_v_reg <= pix_v;
            max_v_reg <= pix_v;
            count_reg <= CW'(1);
        end else if (absorb) begin
            // Raster order means rows never decrease, so min_v stays as allocated.
            if (pix_h < min_h_reg) min_h_reg <= pix_h;
            if (pix_h > max_h_reg) max_h_reg <= pix_h;
            if (pix_v > max_v_reg) max_v_reg <= pix_v;
            if (count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
        end
    end

    assign sum_h    = {1'b0, min_h_reg} + {1'b0, max_h_reg};
    assign sum_v    = {1'b0, min_v_reg} + {1'b0, max_v_reg};
    assign centre_h = sum_h[CW:1];
    assign centre_v = sum_v[CW:1];
    assign valid    = valid_reg;
    assign count    = count_reg;

endmodule

// File: rtl/multi_point_tracker.sv
// Tracks up to MAX_POINTS pixel blobs per frame and publishes their centres at frame end.
// Build option: define MTP_MIN_SIZE_FILTER_EN to drop blobs smaller than MIN_PIXELS.
module multi_point_tracker
    import mtp_pkg::*;
#(
    parameter int MAX_POINTS = 4,
    parameter int CW         = 16,
    parameter int MERGE_DIST = 4,
    parameter int MIN_PIXELS = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     VGA_HS,
    input  logic                     VGA_VS,
    input  logic                     BINARY_FLAG,
    input  logic [CW-1:0]            H_CNT,
    input  logic [CW-1:0]            V_CNT,
    output logic [MAX_POINTS*CW-1:0] o_POINTS_H,
    output logic [MAX_POINTS*CW-1:0] o_POINTS_V,
    output logic [MTP_NUM_W-1:0]     o_POINTS_NUM,
    output logic                     o_VALID,
    output logic                     o_OVERFLOW
);

`ifdef MTP_MIN_SIZE_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    mtp_state_e state_reg, state_next;

    logic                  vs_reg, vs_rise, vs_fall;
    logic                  slot_clr, pix_go, any_match, no_slot;
    logic [MAX_POINTS-1:0] slot_valid, slot_match, slot_absorb, slot_alloc, slot_qual;
    logic [CW-1:0]         slot_ch  [MAX_POINTS];
    logic [CW-1:0]         slot_cv  [MAX_POINTS];
    logic [CW-1:0]         slot_cnt [MAX_POINTS];

    logic                  ovf_flag_reg;
    logic [MTP_NUM_W-1:0]  cmp_idx_reg, out_cnt_reg;
    logic [CW-1:0]         pts_h_reg [MAX_POINTS];
    logic [CW-1:0]         pts_v_reg [MAX_POINTS];
    logic                  valid_reg, ovf_out_reg;
    logic [MTP_NUM_W-1:0]  num_reg;

    logic                  sel_qual;
    logic [CW-1:0]         sel_h, sel_v;

    assign vs_rise   = VGA_VS & ~vs_reg;
    assign vs_fall   = ~VGA_VS & vs_reg;
    assign slot_clr  = (state_reg == IDLE) && vs_rise;
    assign pix_go    = (state_reg == ACCUM) && VGA_VS && VGA_HS && BINARY_FLAG;
    assign any_match = |slot_match;
    assign no_slot   = pix_go && !any_match && (&slot_valid);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_POINTS; gi++) begin : g_slot
            mtp_slot #(
                .CW         (CW),
                .MERGE_DIST (MERGE_DIST)
            ) u_slot (
                .clk      (CLK),
                .rst      (RST),
                .clr      (slot_clr),
                .alloc    (slot_alloc[gi]),
                .absorb   (slot_absorb[gi]),
                .pix_h    (H_CNT),
                .pix_v    (V_CNT),
                .valid    (slot_valid[gi]),
                .match    (slot_match[gi]),
                .centre_h (slot_ch[gi]),
                .centre_v (slot_cv[gi]),
                .count    (slot_cnt[gi])
            );

            assign slot_qual[gi] = slot_valid[gi] && (!FILTER_EN || (slot_cnt[gi] >= MIN_CNT));

            assign o_POINTS_H[gi*CW +: CW] = pts_h_reg[gi];
            assign o_POINTS_V[gi*CW +: CW] = pts_v_reg[gi];
        end
    endgenerate

    // Lowest-index match absorbs; otherwise lowest-index free slot allocates.
    always_comb begin
        logic taken_match, taken_free;
        slot_absorb = '0;
        slot_alloc  = '0;
        taken_match = 1'b0;
        taken_free  = 1'b0;
        for (int k = 0; k < MAX_POINTS; k++) begin
            if (slot_match[k] && !taken_match) begin
                slot_absorb[k] = pix_go;
                taken_match    = 1'b1;
            end
            if (!slot_valid[k] && !any_match && !taken_free) begin
                slot_alloc[k] = pix_go;
                taken_free    = 1'b1;
            end
        end
    end

    always_comb begin
        sel_qual = 1'b0;
        sel_h    = '0;
        sel_v    = '0;
        for (int k = 0; k < MAX_POINTS; k++) begin
            if (cmp_idx_reg == MTP_NUM_W'(k)) begin
                sel_qual = slot_qual[k];
                sel_h    = slot_ch[k];
                sel_v    = slot_cv[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (vs_rise) state_next = ACCUM;
            ACCUM:   if (vs_fall) state_next = COMPACT;
            COMPACT: if (cmp_idx_reg == MTP_NUM_W'(MAX_POINTS-1)) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vs_reg       <= 1'b0;
            ovf_flag_reg <= 1'b0;
            cmp_idx_reg  <= '0;
            out_cnt_reg  <= '0;
            valid_reg    <= 1'b0;
            ovf_out_reg  <= 1'b0;
            num_reg      <= '0;
            for (int k = 0; k < MAX_POINTS; k++) begin
                pts_h_reg[k] <= '0;
                pts_v_reg[k] <= '0;
            end
        end else begin
            vs_reg    <= VGA_VS;
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (vs_rise) ovf_flag_reg <= 1'b0;
                end
                ACCUM: begin
                    if (no_slot) ovf_flag_reg <= 1'b1;
                    cmp_idx_reg <= '0;
                    out_cnt_reg <= '0;
                end
                COMPACT: begin
                    cmp_idx_reg <= cmp_idx_reg + 1'b1;
                    if (sel_qual) out_cnt_reg <= out_cnt_reg + 1'b1;
                    // Entries at or beyond the write pointer are zeroed until a later centre lands there.
                    for (int k = 0; k < MAX_POINTS; k++) begin
                        if (sel_qual && (out_cnt_reg == MTP_NUM_W'(k))) begin
                            pts_h_reg[k] <= sel_h;
                            pts_v_reg[k] <= sel_v;
                        end else if (MTP_NUM_W'(k) >= out_cnt_reg) begin
                            pts_h_reg[k] <= '0;
                            pts_v_reg[k] <= '0;
                        end
                    end
                end
                PUBLISH: begin
                    valid_reg   <= 1'b1;
                    num_reg     <= out_cnt_reg;
                    ovf_out_reg <= ovf_flag_reg;
                end
                default: ;
            endcase
        end
    end

    assign o_VALID      = valid_reg;
    assign o_POINTS_NUM = num_reg;
    assign o_OVERFLOW   = ovf_out_reg;

endmodule

// File: tb/tb_multi_point_tracker.sv
// Randomised and directed frames checked against a pixel-list blob model held in the bench.
module tb_multi_point_tracker;

    localparam int MP     = 4;
    localparam int CWB    = 16;
    localparam int MD     = 4;
    localparam int MINPIX = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             VGA_HS = 1'b0;
    logic             VGA_VS = 1'b0;
    logic             BINARY_FLAG = 1'b0;
    logic [CWB-1:0]   H_CNT = '0;
    logic [CWB-1:0]   V_CNT = '0;
    logic [MP*CWB-1:0] o_POINTS_H, o_POINTS_V;
    logic [4:0]       o_POINTS_NUM;
    logic             o_VALID, o_OVERFLOW;

    multi_point_tracker #(
        .MAX_POINTS (MP),
        .CW         (CWB),
        .MERGE_DIST (MD),
        .MIN_PIXELS (MINPIX)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .BINARY_FLAG  (BINARY_FLAG),
        .H_CNT        (H_CNT),
        .V_CNT        (V_CNT),
        .o_POINTS_H   (o_POINTS_H),
        .o_POINTS_V   (o_POINTS_V),
        .o_POINTS_NUM (o_POINTS_NUM),
        .o_VALID      (o_VALID),
        .o_OVERFLOW   (o_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int     n_vec  = 0;
    int     n_miss = 0;
    int     valid_pulses = 0;
    longint pix[$];
    int     exp_h[MP];
    int     exp_v[MP];
    int     exp_num;
    int     exp_ovf;

    always @(negedge CLK) if (o_VALID === 1'b1) valid_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic add_pix(input int h, input int v);
        pix.push_back((longint'(v) << 16) | longint'(h));
    endtask

    task automatic add_rect(input int h0, input int v0, input int w, input int ht);
        for (int dv = 0; dv < ht; dv++)
            for (int dh = 0; dh < w; dh++)
                add_pix(h0 + dh, v0 + dv);
    endtask

    // Greedy blob grouping straight from the stated merge/allocate rules, on plain integers.
    task automatic model_frame();
        int mv[MP], mnh[MP], mxh[MP], mnv[MP], mxv[MP], mc[MP];
        int h, v, hit, free_k, n;
        bit q;
        for (int k = 0; k < MP; k++) begin
            mv[k] = 0; mnh[k] = 0; mxh[k] = 0; mnv[k] = 0; mxv[k] = 0; mc[k] = 0;
        end
        exp_ovf = 0;
        foreach (pix[i]) begin
            h = int'(pix[i] & 64'hFFFF);
            v = int'(pix[i] >> 16);
            hit = -1;
            free_k = -1;
            for (int k = MP - 1; k >= 0; k--) begin
                if (mv[k] != 0 && h + MD >= mnh[k] && h <= mxh[k] + MD && v <= mxv[k] + MD) hit = k;
                if (mv[k] == 0) free_k = k;
            end
            if (hit >= 0) begin
                if (h < mnh[hit]) mnh[hit] = h;
                if (h > mxh[hit]) mxh[hit] = h;
                if (v > mxv[hit]) mxv[hit] = v;
                if (mc[hit] < 65535) mc[hit]++;
            end else if (free_k >= 0) begin
                mv[free_k] = 1; mnh[free_k] = h; mxh[free_k] = h;
                mnv[free_k] = v; mxv[free_k] = v; mc[free_k] = 1;
            end else begin
                exp_ovf = 1;
            end
        end
        n = 0;
        for (int k = 0; k < MP; k++) begin exp_h[k] = 0; exp_v[k] = 0; end
        for (int k = 0; k < MP; k++) begin
            q = (mv[k] != 0);
`ifdef MTP_MIN_SIZE_FILTER_EN
            q = q && (mc[k] >= MINPIX);
`endif
            if (q) begin
                exp_h[n] = (mnh[k] + mxh[k]) / 2;
                exp_v[n] = (mnv[k] + mxv[k]) / 2;
                n++;
            end
        end
        exp_num = n;
    endtask

    task automatic run_frame(input string name);
        int n;
        pix.sort();
        model_frame();
        VGA_VS = 1'b0; VGA_HS = 1'b0; BINARY_FLAG = 1'b0;
        tick(); tick();
        // Active pixel on the VS rising cycle must be discarded.
        VGA_VS = 1'b1; VGA_HS = 1'b1; BINARY_FLAG = 1'b1;
        H_CNT = CWB'($urandom_range(300, 400)); V_CNT = CWB'($urandom_range(0, 5));
        tick();
        foreach (pix[i]) begin
            repeat ($urandom_range(0, 2)) begin
                VGA_HS = 1'($urandom_range(0, 1));
                BINARY_FLAG = !VGA_HS;
                H_CNT = CWB'($urandom_range(0, 500));
                V_CNT = CWB'($urandom);
                tick();
            end
            VGA_HS = 1'b1; BINARY_FLAG = 1'b1;
            H_CNT = CWB'(pix[i] & 64'hFFFF);
            V_CNT = CWB'(pix[i] >> 16);
            tick();
        end
        // Pixel on the VS falling cycle must be ignored.
        VGA_VS = 1'b0; VGA_HS = 1'b1; BINARY_FLAG = 1'b1;
        H_CNT = CWB'($urandom_range(300, 400)); V_CNT = CWB'($urandom_range(200, 300));
        tick();
        VGA_HS = 1'b0; BINARY_FLAG = 1'b0;
        n = 0;
        while (o_VALID !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(MP + 1));
        chk({name, "_num"}, 32'(o_POINTS_NUM), 32'(exp_num));
        chk({name, "_ovf"}, 32'(o_OVERFLOW), 32'(exp_ovf));
        for (int k = 0; k < MP; k++) begin
            chk($sformatf("%s_h%0d", name, k), 32'(o_POINTS_H[k*CWB +: CWB]), 32'(exp_h[k]));
            chk($sformatf("%s_v%0d", name, k), 32'(o_POINTS_V[k*CWB +: CWB]), 32'(exp_v[k]));
        end
        tick();
        chk({name, "_valid_pulse"}, 32'(o_VALID), 32'd0);
        $display("frame %s: pixels=%0d num=%0d ovf=%0d latency=%0d", name, pix.size(), o_POINTS_NUM, o_OVERFLOW, n);
    endtask

    initial begin
        int pulses_before;
        #1;
        chk("rst_h", 32'(o_POINTS_H), 32'd0);
        chk("rst_v", 32'(o_POINTS_V), 32'd0);
        chk("rst_num", 32'(o_POINTS_NUM), 32'd0);
        chk("rst_valid", 32'(o_VALID), 32'd0);
        chk("rst_ovf", 32'(o_OVERFLOW), 32'd0);
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // Single 3x3 blob
        pix.delete(); add_rect(10, 20, 3, 3);
        run_frame("blob1");
        chk("blob1_num_c", 32'(o_POINTS_NUM), 32'd1);
        chk("blob1_h_c", 32'(o_POINTS_H[15:0]), 32'd11);
        chk("blob1_v_c", 32'(o_POINTS_V[15:0]), 32'd21);
        chk("blob1_ovf_c", 32'(o_OVERFLOW), 32'd0);

        // Four blobs, slot order by first raster pixel
        pix.delete();
        add_rect(19, 9, 3, 3); add_rect(79, 9, 3, 3); add_rect(19, 59, 3, 3); add_rect(149, 79, 3, 3);
        run_frame("blob4");
        chk("blob4_num_c", 32'(o_POINTS_NUM), 32'd4);
        chk("blob4_h1_c", 32'(o_POINTS_H[31:16]), 32'd80);
        chk("blob4_v2_c", 32'(o_POINTS_V[47:32]), 32'd60);
        chk("blob4_h3_c", 32'(o_POINTS_H[63:48]), 32'd150);

        // Five blobs overflow four slots, then a clean frame clears the flag
        pix.delete();
        for (int b = 0; b < 5; b++) add_rect(10 + 30 * b, 10, 2, 2);
        run_frame("ovf5");
        chk("ovf5_num_c", 32'(o_POINTS_NUM), 32'd4);
        chk("ovf5_ovf_c", 32'(o_OVERFLOW), 32'd1);
        pix.delete(); add_rect(40, 40, 3, 3);
        run_frame("ovf_clear");
        chk("ovf_clear_c", 32'(o_OVERFLOW), 32'd0);

        // Merge distance boundary
        pix.delete(); add_pix(50, 30); add_pix(53, 30);
        run_frame("merge_in");
        chk("merge_in_num_c", 32'(o_POINTS_NUM), 32'd1);
        chk("merge_in_h_c", 32'(o_POINTS_H[15:0]), 32'd51);
        pix.delete(); add_pix(50, 30); add_pix(56, 30);
        run_frame("merge_out");
        chk("merge_out_num_c", 32'(o_POINTS_NUM), 32'd2);

        // Size filter build option
        pix.delete(); add_pix(5, 5); add_rect(29, 29, 3, 3);
        run_frame("minsize");
`ifdef MTP_MIN_SIZE_FILTER_EN
        chk("minsize_num_c", 32'(o_POINTS_NUM), 32'd1);
        chk("minsize_h_c", 32'(o_POINTS_H[15:0]), 32'd30);
`else
        chk("minsize_num_c", 32'(o_POINTS_NUM), 32'd2);
        chk("minsize_h_c", 32'(o_POINTS_H[31:16]), 32'd30);
`endif

        // Coordinates at the top of the range: no wrap in compare or centre sum
        pix.delete(); add_pix(65534, 65533); add_pix(65535, 65535); add_pix(65535, 65535); add_pix(65534, 65535);
        run_frame("edge");
        chk("edge_num_c", 32'(o_POINTS_NUM), 32'd1);
        chk("edge_h_c", 32'(o_POINTS_H[15:0]), 32'd65534);
        chk("edge_v_c", 32'(o_POINTS_V[15:0]), 32'd65534);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            pix.delete();
            repeat ($urandom_range(1, 6))
                add_rect($urandom_range(0, 200), $urandom_range(0, 120), $urandom_range(1, 4), $urandom_range(1, 4));
            run_frame($sformatf("rand%0d", f));
        end

        // Reset in the middle of accumulation
        pix.delete(); add_rect(60, 60, 3, 3);
        run_frame("pre_rst");
        VGA_VS = 1'b0; tick(); tick();
        VGA_VS = 1'b1; VGA_HS = 1'b1; BINARY_FLAG = 1'b1; H_CNT = 16'd7; V_CNT = 16'd7;
        tick();
        H_CNT = 16'd8; tick();
        #2 RST = 1'b1;
        #1;
        chk("midrst_h", 32'(o_POINTS_H), 32'd0);
        chk("midrst_v", 32'(o_POINTS_V), 32'd0);
        chk("midrst_num", 32'(o_POINTS_NUM), 32'd0);
        chk("midrst_valid", 32'(o_VALID), 32'd0);
        chk("midrst_ovf", 32'(o_OVERFLOW), 32'd0);
        pulses_before = valid_pulses;
        tick();
        VGA_VS = 1'b0; VGA_HS = 1'b0; BINARY_FLAG = 1'b0;
        tick();
        RST = 1'b0;
        repeat (12) tick();
        chk("midrst_no_valid", 32'(valid_pulses - pulses_before), 32'd0);
        $display("reset mid-frame: valid pulses after reset=%0d", valid_pulses - pulses_before);

        pix.delete(); add_rect(100, 50, 3, 3); add_pix(10, 90);
        run_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
